// File: rtl/pulse_timing_monitor_if.sv
// Result-bank read port and valid/ack handshake of the pulse timing monitor.
// master = monitor side, slave = result consumer.
interface pulse_timing_monitor_if #(
   parameter int NCH = 4,
   parameter int CW  = 16
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [SW-1:0] rd_sel;
   logic [CW-1:0] rd_rise;
   logic [CW-1:0] rd_width;
   logic [7:0]    rd_count;
   logic          res_valid;
   logic          res_ack;
   logic          overrun;
   logic          busy;

   modport master (
      input  rd_sel,
      input  res_ack,
      output rd_rise,
      output rd_width,
      output rd_count,
      output res_valid,
      output overrun,
      output busy
   );

   modport slave (
      output rd_sel,
      output res_ack,
      input  rd_rise,
      input  rd_width,
      input  rd_count,
      input  res_valid,
      input  overrun,
      input  busy
   );
endinterface

// File: rtl/pulse_timing_monitor.sv
// Frame-based checker: per-channel first-rise offset, first-pulse width
// and rising-edge count, latched into a bank and handed off via valid/ack.
module pulse_timing_monitor #(
   parameter int NCH          = 4,
   parameter int CW           = 16,
   parameter int FRAME_CYCLES = 1000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trig_in,
   input  logic [NCH-1:0]        ch_in,
   pulse_timing_monitor_if.master bus
);
   localparam int W = NCH + 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

   state_t state;
   state_t state_nx;

   logic [W-1:0]   sync_q [SYNC_STAGES];
   logic [W-1:0]   prev;
   logic [W-1:0]   lvl;
   logic [W-1:0]   rise_v;
   logic [NCH-1:0] ch_lvl;
   logic [NCH-1:0] ch_rise;
   logic           trig_rise;

   logic [CW-1:0] timer;
   logic          busy;
   logic          start;
   logic          meas;
   logic          commit;

   logic [CW-1:0] w_rise  [NCH];
   logic [CW-1:0] w_width [NCH];
   logic [7:0]    w_cnt   [NCH];
   logic [NCH-1:0] w_seen;
   logic [NCH-1:0] w_open;

   logic [CW-1:0] b_rise  [NCH];
   logic [CW-1:0] b_width [NCH];
   logic [7:0]    b_cnt   [NCH];
   logic          valid_q;
   logic          ovr_q;

   // Trigger and channels share one synchronizer chain so offsets stay pin-relative.
   assign lvl       = sync_q[SYNC_STAGES-1];
   assign rise_v    = lvl & ~prev;
   assign trig_rise = rise_v[NCH];
   assign ch_lvl    = lvl[NCH-1:0];
   assign ch_rise   = rise_v[NCH-1:0];

   // Synchronizer flops plus the one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= {trig_in, ch_in};
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         prev <= lvl;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FSM next state: a trigger in MEAS restarts the frame.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (trig_rise) state_nx = MEAS;
         MEAS: begin
            if (trig_rise)          state_nx = MEAS;
            else if (timer == LAST) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: trigger cycle is frame offset 0, MEAS covers the rest.
   always_comb begin
      busy   = 1'b0;
      start  = 1'b0;
      meas   = 1'b0;
      commit = 1'b0;
      unique case (state)
         IDLE: start = trig_rise;
         MEAS: begin
            busy  = 1'b1;
            meas  = 1'b1;
            start = trig_rise;
         end
         DONE:    commit = 1'b1;
         default: ;
      endcase
   end

   // Frame timer; the trigger cycle is offset 0 so MEAS resumes at 1.
   always_ff @(posedge clk) begin
      if (rst)       timer <= '0;
      else if (start) timer <= CW'(1);
      else if (meas)  timer <= timer + CW'(1);
      else            timer <= '0;
   end

   // Per-channel working measurements for the frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            w_rise[i]  <= '1;
            w_width[i] <= '0;
            w_cnt[i]   <= '0;
         end
         w_seen <= '0;
         w_open <= '0;
      end else if (start) begin
         for (int i = 0; i < NCH; i++) begin
            w_rise[i]  <= ch_rise[i] ? '0 : '1;
            w_width[i] <= ch_rise[i] ? CW'(1) : '0;
            w_cnt[i]   <= ch_rise[i] ? 8'd1 : 8'd0;
         end
         w_seen <= ch_rise;
         w_open <= ch_rise;
      end else if (meas) begin
         for (int i = 0; i < NCH; i++) begin
            if (ch_rise[i] && w_cnt[i] != 8'hFF)
               w_cnt[i] <= w_cnt[i] + 8'd1;
            if (ch_rise[i] && !w_seen[i]) begin
               w_seen[i]  <= 1'b1;
               w_open[i]  <= 1'b1;
               w_rise[i]  <= timer;
               w_width[i] <= CW'(1);
            end else if (w_open[i]) begin
               if (!ch_lvl[i])
                  w_open[i] <= 1'b0;
               else if (w_width[i] != '1)
                  w_width[i] <= w_width[i] + CW'(1);
            end
         end
      end
   end

   // Result bank and handshake: commit beats a same-cycle ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            b_rise[i]  <= '1;
            b_width[i] <= '0;
            b_cnt[i]   <= '0;
         end
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (commit) begin
         if (!valid_q || bus.res_ack) begin
            for (int i = 0; i < NCH; i++) begin
               b_rise[i]  <= w_rise[i];
               b_width[i] <= w_width[i];
               b_cnt[i]   <= w_cnt[i];
            end
            valid_q <= 1'b1;
         end else begin
            ovr_q <= 1'b1;
         end
      end else if (bus.res_ack) begin
         valid_q <= 1'b0;
      end
   end

   // Combinational bank read; out-of-range selects read zero.
   always_comb begin
      bus.rd_rise  = '0;
      bus.rd_width = '0;
      bus.rd_count = '0;
      if (int'(bus.rd_sel) < NCH) begin
         bus.rd_rise  = b_rise[bus.rd_sel];
         bus.rd_width = b_width[bus.rd_sel];
         bus.rd_count = b_cnt[bus.rd_sel];
      end
   end

   assign bus.res_valid = valid_q;
   assign bus.overrun   = ovr_q;
   assign bus.busy      = busy;
endmodule

// File: tb/tb_pulse_timing_monitor.sv
// Bench for pulse_timing_monitor: directed frames with random channel
// activity, checked against a frame-scan reference model.
module tb_pulse_timing_monitor;
   localparam int NCH   = 4;
   localparam int CW    = 16;
   localparam int FRAME = 1000;
   localparam int SYNC  = 2;
   localparam int LAT   = SYNC;
   localparam int MAXS  = 1400;

   logic           clk = 1'b0;
   logic           rst;
   logic           trig_in;
   logic [NCH-1:0] ch_in;

   pulse_timing_monitor_if #(.NCH(NCH), .CW(CW)) bus ();

   pulse_timing_monitor #(
      .NCH(NCH), .CW(CW), .FRAME_CYCLES(FRAME), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .rst(rst), .trig_in(trig_in), .ch_in(ch_in), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   logic [NCH-1:0] chp [MAXS];
   logic [CW-1:0]  er [NCH];
   logic [CW-1:0]  ew [NCH];
   logic [7:0]     en [NCH];
   logic [CW-1:0]  nr [NCH];
   logic [CW-1:0]  nw [NCH];
   logic [7:0]     nn [NCH];
   logic           mv;
   logic           movr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: scan the frame window for rising edges and the first run of ones.
   task automatic model_frame(input logic [NCH-1:0] pre, input int base);
      for (int c = 0; c < NCH; c++) begin
         logic p;
         int first;
         int run;
         int edges;
         p = (base == 0) ? pre[c] : chp[base-1][c];
         first = -1;
         edges = 0;
         for (int k = 0; k < FRAME; k++) begin
            if (chp[base+k][c] && !p) begin
               edges++;
               if (first < 0) first = k;
            end
            p = chp[base+k][c];
         end
         run = 0;
         if (first >= 0)
            while (first + run < FRAME && chp[base+first+run][c]) run++;
         nr[c] = (first < 0) ? '1 : CW'(first);
         nw[c] = CW'(run);
         nn[c] = (edges > 255) ? 8'hFF : 8'(edges);
      end
   endtask

   task automatic check_bank(input string tag);
      for (int c = 0; c < NCH; c++) begin
         bus.rd_sel = 2'(c);
         #1;
         chk($sformatf("%s rise%0d", tag, c), 32'(bus.rd_rise), 32'(er[c]));
         chk($sformatf("%s width%0d", tag, c), 32'(bus.rd_width), 32'(ew[c]));
         chk($sformatf("%s count%0d", tag, c), 32'(bus.rd_count), 32'(en[c]));
      end
      bus.rd_sel = '0;
   endtask

   task automatic read_ch(input int c, output logic [CW-1:0] r,
                          output logic [CW-1:0] w, output logic [7:0] n);
      bus.rd_sel = 2'(c);
      #1;
      r = bus.rd_rise;
      w = bus.rd_width;
      n = bus.rd_count;
      bus.rd_sel = '0;
   endtask

   task automatic rand_ch(input int c, input int from, input int to);
      logic l;
      l = 1'b0;
      for (int s = from; s < to; s++) begin
         if ($urandom_range(0, 19) == 0) l = ~l;
         chp[s][c] = l;
      end
   endtask

   task automatic ack();
      bus.res_ack = 1'b1;
      tick();
      bus.res_ack = 1'b0;
      mv = 1'b0;
      chk("ack valid", 32'(bus.res_valid), 32'(mv));
      chk("ack overrun", 32'(bus.overrun), 32'(movr));
   endtask

   task automatic run_frame(input string tag, input logic [NCH-1:0] pre,
                            input int retrig, input int ack_at);
      int  base;
      int  done_s;
      int  vstep;
      bit  early;
      base   = (retrig > 0) ? retrig : 0;
      done_s = base + LAT + FRAME;
      vstep  = done_s + 1;
      model_frame(pre, base);
      trig_in     = 1'b0;
      ch_in       = pre;
      bus.res_ack = 1'b0;
      repeat (4) tick();
      early = 1'b0;
      for (int s = 0; s <= vstep; s++) begin
         if (s < done_s && bus.res_valid !== mv) early = 1'b1;
         if (s == base + LAT + 1)
            chk({tag, " busy start"}, 32'(bus.busy), 32'd1);
         if (s == done_s - 1)
            chk({tag, " busy last"}, 32'(bus.busy), 32'd1);
         if (s == done_s) begin
            chk({tag, " busy done"}, 32'(bus.busy), 32'd0);
            chk({tag, " valid pre"}, 32'(bus.res_valid), 32'(mv));
         end
         if (s == vstep) begin
            if (!mv || ack_at == done_s) begin
               for (int c = 0; c < NCH; c++) begin
                  er[c] = nr[c];
                  ew[c] = nw[c];
                  en[c] = nn[c];
               end
               mv = 1'b1;
            end else begin
               movr = 1'b1;
            end
            chk({tag, " valid"}, 32'(bus.res_valid), 32'(mv));
            chk({tag, " overrun"}, 32'(bus.overrun), 32'(movr));
            chk({tag, " no early valid"}, 32'(early), 32'd0);
            check_bank(tag);
         end else begin
            trig_in = (s < 5) || (retrig > 0 && s >= retrig && s < retrig + 5);
            ch_in   = (s < base + FRAME) ? chp[s] : chp[base+FRAME-1];
            bus.res_ack = (s == ack_at);
            tick();
         end
      end
      bus.res_ack = 1'b0;
      trig_in     = 1'b0;
   endtask

   initial begin
      logic [CW-1:0] r;
      logic [CW-1:0] w;
      logic [7:0]    n;
      bit            early;

      rst         = 1'b1;
      trig_in     = 1'b0;
      ch_in       = '0;
      bus.rd_sel  = '0;
      bus.res_ack = 1'b0;
      mv          = 1'b0;
      movr        = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         er[c] = '1;
         ew[c] = '0;
         en[c] = '0;
      end
      for (int s = 0; s < MAXS; s++) chp[s] = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset valid", 32'(bus.res_valid), 32'd0);
      chk("reset overrun", 32'(bus.overrun), 32'd0);
      check_bank("reset");

      for (int s = 0; s < FRAME; s++) begin
         chp[s][0] = (s >= 10 && s <= 12) || (s >= 50 && s <= 52);
         chp[s][2] = 1'b0;
         chp[s][3] = 1'b1;
      end
      rand_ch(1, 0, FRAME);
      run_frame("nominal", 4'b1000, 0, -1);
      read_ch(0, r, w, n);
      chk("nominal ch0 rise", 32'(r), 32'd10);
      chk("nominal ch0 width", 32'(w), 32'd3);
      chk("nominal ch0 count", 32'(n), 32'd2);
      read_ch(2, r, w, n);
      chk("silent ch2 rise", 32'(r), 32'hFFFF);
      chk("silent ch2 count", 32'(n), 32'd0);
      read_ch(3, r, w, n);
      chk("held ch3 rise", 32'(r), 32'hFFFF);
      chk("held ch3 count", 32'(n), 32'd0);
      ack();

      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < NCH; c++) rand_ch(c, 0, FRAME);
         run_frame($sformatf("random%0d", f), 4'($urandom_range(0, 15)), 0, -1);
         ack();
      end

      for (int s = 0; s < FRAME; s++) begin
         chp[s][0] = s[0];
         chp[s][1] = (s >= 995);
         chp[s][2] = (s < 4);
         chp[s][3] = 1'b1;
      end
      run_frame("edges", 4'b1000, 0, -1);
      read_ch(0, r, w, n);
      chk("edges ch0 count sat", 32'(n), 32'd255);
      read_ch(1, r, w, n);
      chk("edges ch1 rise", 32'(r), 32'd995);
      chk("edges ch1 width", 32'(w), 32'd5);
      read_ch(2, r, w, n);
      chk("edges ch2 rise at trig", 32'(r), 32'd0);

      for (int c = 0; c < NCH; c++) rand_ch(c, 0, FRAME);
      run_frame("commit+ack", '0, 0, LAT + FRAME);
      ack();

      for (int c = 0; c < NCH; c++) rand_ch(c, 0, FRAME);
      run_frame("ovr frame1", '0, 0, -1);
      for (int c = 0; c < NCH; c++) rand_ch(c, 0, FRAME);
      run_frame("ovr frame2", '0, 0, -1);
      chk("overrun set", 32'(bus.overrun), 32'd1);
      ack();
      chk("overrun sticky", 32'(bus.overrun), 32'd1);

      for (int c = 0; c < NCH; c++) rand_ch(c, 0, MAXS);
      for (int s = 299; s < MAXS; s++)
         chp[s][1] = (s >= 320 && s <= 330);
      run_frame("retrig", '0, 300, -1);
      read_ch(1, r, w, n);
      chk("retrig ch1 rise", 32'(r), 32'd20);
      chk("retrig ch1 width", 32'(w), 32'd11);
      ack();

      for (int c = 0; c < NCH; c++) rand_ch(c, 0, FRAME);
      trig_in = 1'b0;
      ch_in   = '0;
      repeat (4) tick();
      for (int s = 0; s < 500; s++) begin
         trig_in = (s < 5);
         ch_in   = chp[s];
         tick();
      end
      chk("midrst busy before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mv   = 1'b0;
      movr = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         er[c] = '1;
         ew[c] = '0;
         en[c] = '0;
      end
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst valid", 32'(bus.res_valid), 32'd0);
      chk("midrst overrun", 32'(bus.overrun), 32'd0);
      early = 1'b0;
      for (int s = 500; s < 1600; s++) begin
         ch_in = (s < FRAME) ? chp[s] : '0;
         tick();
         if (bus.res_valid !== 1'b0) early = 1'b1;
      end
      chk("midrst no valid", 32'(early), 32'd0);
      check_bank("midrst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end
endmodule
